imem_arbiter: RTL and testbench
===============================

Name: imem_arbiter

Overview:
- Shares the single memory refill port between the instruction-cache side (read-only) and the data-cache side (read/write).
- Sits between the icache/dcache miss logic and the memory/bus adapter.
- One transaction in flight at a time, round-robin arbitration, response routed back to the owning requester.
- Instruction-side responses can be discarded on pipeline flush without breaking the memory handshake.

Parameters:
- ADDR_W, XLEN (mmm_pkg): request address width.
- DATA_W, 128: refill/writeback line width.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- flush_i  in  1  pipeline flush; drops any pending instruction-side response
- ic_addr_i  in  ADDR_W  icache request address
- ic_addr_valid_i  in  1  icache request valid
- ic_addr_ready_o  out  1  icache request accepted
- ic_data_o  out  DATA_W  icache response data
- ic_data_valid_o  out  1  icache response valid
- ic_data_ready_i  in  1  icache response ready
- dc_addr_i  in  ADDR_W  dcache request address
- dc_we_i  in  1  dcache write (1) / read (0)
- dc_wdata_i  in  DATA_W  dcache write line
- dc_addr_valid_i  in  1  dcache request valid
- dc_addr_ready_o  out  1  dcache request accepted
- dc_data_o  out  DATA_W  dcache response data (write ack: don't-care)
- dc_data_valid_o  out  1  dcache response valid
- dc_data_ready_i  in  1  dcache response ready
- mem_addr_o  out  ADDR_W  memory request address
- mem_we_o  out  1  memory write enable
- mem_wdata_o  out  DATA_W  memory write data
- mem_addr_valid_o  out  1  memory request valid
- mem_addr_ready_i  in  1  memory request ready
- mem_data_i  in  DATA_W  memory response data
- mem_data_valid_i  in  1  memory response valid
- mem_data_ready_o  out  1  memory response ready

Behaviour:
- Reset (async): state IDLE, prio=IC, owner=IC, drop=0, address/wdata/we registers 0. All valid/ready outputs 0.
- States: IDLE, ADDR, DATA.
- IDLE:
  - grant = IC if only ic valid; DC if only dc valid.
  - If both are valid, grant goes to prio.
  - Granted side's addr_ready_o=1 combinationally; the other side's is 0.
  - On grant, register addr/we/wdata (we=0, wdata=0 for IC), set owner, set prio to the non-granted side, go to ADDR.
  - If neither is valid, stay.
- ADDR:
  - mem_addr_valid_o=1 (Moore), with mem_addr_o/we/wdata from registers, stable until handshake.
  - On mem_addr_ready_i, go to DATA.
  - Minimum request-to-memory latency: 1 cycle after requester handshake.
- DATA:
  - Response routed to owner: owner_data_valid_o = mem_data_valid_i & !drop; owner_data_o = mem_data_i.
  - mem_data_ready_o = drop ? 1 : owner_data_ready_i.
  - On mem_data_valid_i & mem_data_ready_o: go to IDLE, clear drop.
  - The non-owner's data_valid_o is always 0.
- Response backpressure passes through combinationally; no response buffering.
- flush_i:
  - Sets drop=1 when owner=IC and state is ADDR or DATA, including the cycle of the IDLE->ADDR grant to IC.
  - The memory transaction still completes; the data is consumed and never presented to the icache.
  - flush_i with owner=DC has no effect.
  - flush_i in IDLE blocks no new grant.
- Data-side writes:
  - Memory returns one response beat as the write ack; it is routed to dc_data_valid_o like a read.
- Prio toggles only on a contested or uncontested grant, never on a response.
- No new grant until the current response handshake completes; back-to-back transactions are separated by at least 1 IDLE cycle.
- Reset mid-transaction: immediate return to IDLE; the memory side must tolerate the abandoned request.

Test Plan:
- Single IC read 0x0000_1000, mem ready at once, data 0xA5 after 3 cycles: ic_addr_ready_o=1 at cycle 0; mem_addr_valid_o=1 at cycle 1 with addr 0x1000; ic_data_valid_o=1 with 0xA5; dc outputs stay 0.
- Both valid every cycle from reset (IC 0x100, DC 0x200): grants alternate IC, DC, IC, DC; mem_addr_o sequence is 0x100, 0x200, 0x100, 0x200.
- DC write 0x300, wdata 0xDEAD: mem_we_o=1, mem_wdata_o=0xDEAD; ack beat gives dc_data_valid_o=1; ic_data_valid_o=0.
- mem_addr_ready_i held low 5 cycles: mem_addr_valid_o, addr and we stay constant all 5 cycles; no other requester is granted.
- IC read, flush_i pulsed in DATA before mem_data_valid_i: mem_data_ready_o=1; ic_data_valid_o stays 0; FSM returns to IDLE; the next IC request is granted normally.
- IC response with ic_data_ready_i low 4 cycles: mem_data_ready_o=0 for those cycles; the transfer completes on the first cycle ic_data_ready_i=1; async reset asserted mid-DATA returns all outputs to 0 immediately.

Source files
------------

// File: rtl/imem_arbiter_if.sv
// Bundle of the icache, dcache and memory-port handshakes around the refill arbiter.
// slave is the arbiter's view; master is the environment (caches plus memory adapter).
interface imem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 128
);
  logic [ADDR_W-1:0] ic_addr_i;
  logic              ic_addr_valid_i;
  logic              ic_addr_ready_o;
  logic [DATA_W-1:0] ic_data_o;
  logic              ic_data_valid_o;
  logic              ic_data_ready_i;

  logic [ADDR_W-1:0] dc_addr_i;
  logic              dc_we_i;
  logic [DATA_W-1:0] dc_wdata_i;
  logic              dc_addr_valid_i;
  logic              dc_addr_ready_o;
  logic [DATA_W-1:0] dc_data_o;
  logic              dc_data_valid_o;
  logic              dc_data_ready_i;

  logic [ADDR_W-1:0] mem_addr_o;
  logic              mem_we_o;
  logic [DATA_W-1:0] mem_wdata_o;
  logic              mem_addr_valid_o;
  logic              mem_addr_ready_i;
  logic [DATA_W-1:0] mem_data_i;
  logic              mem_data_valid_i;
  logic              mem_data_ready_o;

  modport slave (
    input  ic_addr_i, ic_addr_valid_i, ic_data_ready_i,
    output ic_addr_ready_o, ic_data_o, ic_data_valid_o,
    input  dc_addr_i, dc_we_i, dc_wdata_i, dc_addr_valid_i, dc_data_ready_i,
    output dc_addr_ready_o, dc_data_o, dc_data_valid_o,
    output mem_addr_o, mem_we_o, mem_wdata_o, mem_addr_valid_o, mem_data_ready_o,
    input  mem_addr_ready_i, mem_data_i, mem_data_valid_i
  );

  modport master (
    output ic_addr_i, ic_addr_valid_i, ic_data_ready_i,
    input  ic_addr_ready_o, ic_data_o, ic_data_valid_o,
    output dc_addr_i, dc_we_i, dc_wdata_i, dc_addr_valid_i, dc_data_ready_i,
    input  dc_addr_ready_o, dc_data_o, dc_data_valid_o,
    input  mem_addr_o, mem_we_o, mem_wdata_o, mem_addr_valid_o, mem_data_ready_o,
    output mem_addr_ready_i, mem_data_i, mem_data_valid_i
  );
endinterface

// File: rtl/imem_arbiter.sv
// Round-robin arbiter sharing one memory refill port between icache (read) and dcache (read/write).
// One transaction in flight; icache responses can be discarded on flush while memory still completes.
module imem_arbiter #(
  parameter int ADDR_W = 32,  // XLEN
  parameter int DATA_W = 128
) (
  input  logic           clk_i,
  input  logic           rst_n_i,
  input  logic           flush_i,
  imem_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;
  typedef enum logic {OWN_IC, OWN_DC} owner_t;

  state_t            r_state;
  state_t            w_nextState;
  owner_t            r_prio;
  owner_t            r_owner;
  logic              r_drop;
  logic [ADDR_W-1:0] r_addr;
  logic              r_we;
  logic [DATA_W-1:0] r_wdata;

  logic w_grantIc;
  logic w_grantDc;
  logic w_ownerReady;
  logic w_memDataReady;
  logic w_respDone;

  // Grants are gated by reset so no requester sees a ready while the block is held in reset.
  always_comb begin
    w_grantIc = 1'b0;
    w_grantDc = 1'b0;
    if (r_state == S_IDLE && rst_n_i) begin
      if (bus.ic_addr_valid_i && (!bus.dc_addr_valid_i || r_prio == OWN_IC)) begin
        w_grantIc = 1'b1;
      end else if (bus.dc_addr_valid_i) begin
        w_grantDc = 1'b1;
      end
    end
  end

  always_comb begin
    w_nextState    = r_state;
    w_ownerReady   = (r_owner == OWN_IC) ? bus.ic_data_ready_i : bus.dc_data_ready_i;
    w_memDataReady = 1'b0;
    w_respDone     = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_grantIc || w_grantDc) begin
          w_nextState = S_ADDR;
        end
      end
      S_ADDR: begin
        if (bus.mem_addr_ready_i) begin
          w_nextState = S_DATA;
        end
      end
      S_DATA: begin
        w_memDataReady = r_drop | w_ownerReady;
        w_respDone     = bus.mem_data_valid_i & w_memDataReady;
        if (w_respDone) begin
          w_nextState = S_IDLE;
        end
      end
      default: w_nextState = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_prio  <= OWN_IC;
      r_owner <= OWN_IC;
      r_drop  <= 1'b0;
      r_addr  <= '0;
      r_we    <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_state <= w_nextState;
      if (w_grantIc) begin
        r_addr  <= bus.ic_addr_i;
        r_we    <= 1'b0;
        r_wdata <= '0;
        r_owner <= OWN_IC;
        r_prio  <= OWN_DC;
        r_drop  <= flush_i;
      end else if (w_grantDc) begin
        r_addr  <= bus.dc_addr_i;
        r_we    <= bus.dc_we_i;
        r_wdata <= bus.dc_wdata_i;
        r_owner <= OWN_DC;
        r_prio  <= OWN_IC;
        r_drop  <= 1'b0;
      end else if (w_respDone) begin
        r_drop <= 1'b0;
      end else if (flush_i && r_owner == OWN_IC && r_state != S_IDLE) begin
        r_drop <= 1'b1;
      end
    end
  end

  assign bus.ic_addr_ready_o  = w_grantIc;
  assign bus.dc_addr_ready_o  = w_grantDc;

  assign bus.mem_addr_valid_o = (r_state == S_ADDR);
  assign bus.mem_addr_o       = r_addr;
  assign bus.mem_we_o         = r_we;
  assign bus.mem_wdata_o      = r_wdata;
  assign bus.mem_data_ready_o = w_memDataReady;

  // Response data passes straight through; only the valids are steered and masked.
  assign bus.ic_data_o        = bus.mem_data_i;
  assign bus.dc_data_o        = bus.mem_data_i;
  assign bus.ic_data_valid_o  = (r_state == S_DATA) && (r_owner == OWN_IC) && bus.mem_data_valid_i && !r_drop;
  assign bus.dc_data_valid_o  = (r_state == S_DATA) && (r_owner == OWN_DC) && bus.mem_data_valid_i;

endmodule

// File: tb/tb_imem_arbiter.sv
// Directed bench for imem_arbiter: single reads, round-robin alternation, writes,
// address stall, flush drop, response backpressure and mid-transaction reset.
module tb_imem_arbiter;

  localparam int ADDR_W = 32;
  localparam int DATA_W = 128;

  logic clk_i;
  logic rst_n_i;
  logic flush_i;

  int testsRun;
  int testsFailed;

  imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  imem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .flush_i (flush_i),
    .bus     (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [DATA_W-1:0] observed,
                             input logic [DATA_W-1:0] expected);
    testsRun++;
    if (observed !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic icValid, input logic [ADDR_W-1:0] icAddr,
                               input logic dcValid, input logic [ADDR_W-1:0] dcAddr,
                               input logic dcWe, input logic [DATA_W-1:0] dcWdata);
    bus.ic_addr_valid_i = icValid;
    bus.ic_addr_i       = icAddr;
    bus.dc_addr_valid_i = dcValid;
    bus.dc_addr_i       = dcAddr;
    bus.dc_we_i         = dcWe;
    bus.dc_wdata_i      = dcWdata;
    #1;
  endtask

  task automatic doReset();
    rst_n_i = 1'b0;
    flush_i = 1'b0;
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    bus.ic_data_ready_i  = 1'b0;
    bus.dc_data_ready_i  = 1'b0;
    bus.mem_addr_ready_i = 1'b0;
    bus.mem_data_i       = '0;
    bus.mem_data_valid_i = 1'b0;
    tick();
    tick();
    rst_n_i = 1'b1;
  endtask

  // Called one cycle after a grant: checks the address phase, accepts it, then returns one beat.
  task automatic memServe(input string tag, input logic [ADDR_W-1:0] expAddr, input logic expWe,
                          input logic [DATA_W-1:0] expWdata, input logic [DATA_W-1:0] rdata,
                          input logic toDc);
    checkOutput({tag, ".addrValid"}, DATA_W'(bus.mem_addr_valid_o), 1);
    checkOutput({tag, ".addr"}, DATA_W'(bus.mem_addr_o), DATA_W'(expAddr));
    checkOutput({tag, ".we"}, DATA_W'(bus.mem_we_o), DATA_W'(expWe));
    checkOutput({tag, ".wdata"}, bus.mem_wdata_o, expWdata);
    bus.mem_addr_ready_i = 1'b1;
    tick();
    bus.mem_addr_ready_i = 1'b0;
    bus.mem_data_i       = rdata;
    bus.mem_data_valid_i = 1'b1;
    bus.ic_data_ready_i  = 1'b1;
    bus.dc_data_ready_i  = 1'b1;
    #1;
    checkOutput({tag, ".addrValidDrop"}, DATA_W'(bus.mem_addr_valid_o), 0);
    checkOutput({tag, ".icValid"}, DATA_W'(bus.ic_data_valid_o), DATA_W'(!toDc));
    checkOutput({tag, ".dcValid"}, DATA_W'(bus.dc_data_valid_o), DATA_W'(toDc));
    checkOutput({tag, ".data"}, toDc ? bus.dc_data_o : bus.ic_data_o, rdata);
    checkOutput({tag, ".memReady"}, DATA_W'(bus.mem_data_ready_o), 1);
    tick();
    bus.mem_data_valid_i = 1'b0;
    bus.ic_data_ready_i  = 1'b0;
    bus.dc_data_ready_i  = 1'b0;
  endtask

  initial begin
    logic [ADDR_W-1:0] expAddr [4];
    testsRun    = 0;
    testsFailed = 0;
    expAddr[0] = 32'h100;
    expAddr[1] = 32'h200;
    expAddr[2] = 32'h100;
    expAddr[3] = 32'h200;

    doReset();
    rst_n_i = 1'b0;
    applyStimulus(1'b1, 32'h1000, 1'b1, 32'h2000, 1'b0, '0);
    checkOutput("rst.icReady", DATA_W'(bus.ic_addr_ready_o), 0);
    checkOutput("rst.dcReady", DATA_W'(bus.dc_addr_ready_o), 0);
    checkOutput("rst.memValid", DATA_W'(bus.mem_addr_valid_o), 0);
    checkOutput("rst.memAddr", DATA_W'(bus.mem_addr_o), 0);
    checkOutput("rst.memReady", DATA_W'(bus.mem_data_ready_o), 0);
    doReset();

    // Single icache read
    applyStimulus(1'b1, 32'h0000_1000, 1'b0, '0, 1'b0, '0);
    checkOutput("ic1.grant", DATA_W'(bus.ic_addr_ready_o), 1);
    checkOutput("ic1.dcReady", DATA_W'(bus.dc_addr_ready_o), 0);
    tick();
    bus.ic_addr_valid_i = 1'b0;
    checkOutput("ic1.memValidStall", DATA_W'(bus.mem_addr_valid_o), 1);
    bus.mem_addr_ready_i = 1'b1;
    tick();
    bus.mem_addr_ready_i = 1'b0;
    tick();
    tick();
    checkOutput("ic1.noEarlyValid", DATA_W'(bus.ic_data_valid_o), 0);
    bus.mem_data_i       = 128'hA5;
    bus.mem_data_valid_i = 1'b1;
    bus.ic_data_ready_i  = 1'b1;
    #1;
    checkOutput("ic1.icValid", DATA_W'(bus.ic_data_valid_o), 1);
    checkOutput("ic1.icData", bus.ic_data_o, 128'hA5);
    checkOutput("ic1.dcValid", DATA_W'(bus.dc_data_valid_o), 0);
    tick();
    bus.mem_data_valid_i = 1'b0;
    bus.ic_data_ready_i  = 1'b0;

    // Contested requests alternate starting from the icache
    doReset();
    applyStimulus(1'b1, 32'h100, 1'b1, 32'h200, 1'b0, '0);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("rr%0d.icReady", i), DATA_W'(bus.ic_addr_ready_o), DATA_W'(i % 2 == 0));
      checkOutput($sformatf("rr%0d.dcReady", i), DATA_W'(bus.dc_addr_ready_o), DATA_W'(i % 2 == 1));
      tick();
      checkOutput($sformatf("rr%0d.noGrantBusy", i),
                  DATA_W'(bus.ic_addr_ready_o | bus.dc_addr_ready_o), 0);
      memServe($sformatf("rr%0d", i), expAddr[i], 1'b0, '0, 128'(32'hC0 + i), i % 2 == 1);
    end

    // Dcache write: ack beat goes to the dcache only
    applyStimulus(1'b0, '0, 1'b1, 32'h300, 1'b1, 128'hDEAD);
    checkOutput("wr.grant", DATA_W'(bus.dc_addr_ready_o), 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    memServe("wr", 32'h300, 1'b1, 128'hDEAD, 128'h0, 1'b1);

    // Memory address stall: request held steady, no other grant
    applyStimulus(1'b1, 32'h400, 1'b0, '0, 1'b0, '0);
    checkOutput("stall.grant", DATA_W'(bus.ic_addr_ready_o), 1);
    tick();
    applyStimulus(1'b0, '0, 1'b1, 32'h500, 1'b0, '0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d.valid", i), DATA_W'(bus.mem_addr_valid_o), 1);
      checkOutput($sformatf("stall%0d.addr", i), DATA_W'(bus.mem_addr_o), 128'h400);
      checkOutput($sformatf("stall%0d.we", i), DATA_W'(bus.mem_we_o), 0);
      checkOutput($sformatf("stall%0d.dcReady", i), DATA_W'(bus.dc_addr_ready_o), 0);
      tick();
    end
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    memServe("stall", 32'h400, 1'b0, '0, 128'h77, 1'b0);

    // Flush during DATA drops the icache response
    applyStimulus(1'b1, 32'h600, 1'b0, '0, 1'b0, '0);
    tick();
    bus.ic_addr_valid_i  = 1'b0;
    bus.mem_addr_ready_i = 1'b1;
    tick();
    bus.mem_addr_ready_i = 1'b0;
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    bus.mem_data_i       = 128'hBAD;
    bus.mem_data_valid_i = 1'b1;
    #1;
    checkOutput("flush.memReady", DATA_W'(bus.mem_data_ready_o), 1);
    checkOutput("flush.icValid", DATA_W'(bus.ic_data_valid_o), 0);
    tick();
    bus.mem_data_valid_i = 1'b0;
    applyStimulus(1'b1, 32'h640, 1'b0, '0, 1'b0, '0);
    checkOutput("flush.regrant", DATA_W'(bus.ic_addr_ready_o), 1);
    tick();
    applyStimulus(1'b0, '0, 1'b0, '0, 1'b0, '0);
    memServe("afterFlush", 32'h640, 1'b0, '0, 128'h1234, 1'b0);

    // Response backpressure from the icache
    applyStimulus(1'b1, 32'h700, 1'b0, '0, 1'b0, '0);
    tick();
    bus.ic_addr_valid_i  = 1'b0;
    bus.mem_addr_ready_i = 1'b1;
    tick();
    bus.mem_addr_ready_i = 1'b0;
    bus.mem_data_i       = 128'h55;
    bus.mem_data_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checkOutput($sformatf("bp%0d.memReady", i), DATA_W'(bus.mem_data_ready_o), 0);
      checkOutput($sformatf("bp%0d.icValid", i), DATA_W'(bus.ic_data_valid_o), 1);
      tick();
    end
    bus.ic_data_ready_i = 1'b1;
    #1;
    checkOutput("bp.memReady", DATA_W'(bus.mem_data_ready_o), 1);
    tick();
    bus.mem_data_valid_i = 1'b0;
    bus.ic_data_ready_i  = 1'b0;
    applyStimulus(1'b1, 32'h800, 1'b0, '0, 1'b0, '0);
    checkOutput("bp.idleRegrant", DATA_W'(bus.ic_addr_ready_o), 1);

    // Async reset in the middle of DATA
    tick();
    bus.mem_addr_ready_i = 1'b1;
    tick();
    bus.mem_addr_ready_i = 1'b0;
    bus.mem_data_valid_i = 1'b1;
    bus.ic_data_ready_i  = 1'b1;
    #1;
    checkOutput("midRst.before", DATA_W'(bus.ic_data_valid_o), 1);
    rst_n_i = 1'b0;
    #1;
    checkOutput("midRst.icValid", DATA_W'(bus.ic_data_valid_o), 0);
    checkOutput("midRst.memReady", DATA_W'(bus.mem_data_ready_o), 0);
    checkOutput("midRst.memValid", DATA_W'(bus.mem_addr_valid_o), 0);
    checkOutput("midRst.icReady", DATA_W'(bus.ic_addr_ready_o), 0);
    checkOutput("midRst.memAddr", DATA_W'(bus.mem_addr_o), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
